// File: rtl/stepdown_pkg.sv
// Shared types and default constants for the step-down soft-start controller.
// The timer width helper keeps one counter wide enough for every reload value.
package stepdown_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_RAMP      = 3'd2,
        ST_DONE      = 3'd3,
        ST_HICCUP    = 3'd4
    } ss_state_e;

    localparam int DEF_CODE_W     = 6;
    localparam int DEF_FINAL_CODE = 63;
    localparam int DEF_PRESCALE   = 16;
    localparam int DEF_PRE_CYC    = 32;
    localparam int DEF_HICCUP_CYC = 1024;

    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/stepdown_softstart_ctrl_ss_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
// Loading N-1 therefore yields a terminal count N clocks after the load.
module ss_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/stepdown_softstart_ctrl.sv
// Soft-start sequencer for a step-down converter: precharge wait, stepped DAC ramp,
// hold at final code, and hiccup off-time after an overcurrent event.
module stepdown_softstart_ctrl
    import stepdown_pkg::*;
#(
    parameter int CODE_W     = DEF_CODE_W,
    parameter int FINAL_CODE = DEF_FINAL_CODE,
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int PRE_CYC    = DEF_PRE_CYC,
    parameter int HICCUP_CYC = DEF_HICCUP_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic              en,
    input  logic              uvlo_ok,
    input  logic              oc_fault,
    output logic [CODE_W-1:0] ref_code,
    output logic              drv_en,
    output logic              ss_active,
    output logic              ss_done,
    output logic              fault_flag
);

    localparam int CNT_W = timer_width(PRE_CYC, PRESCALE, HICCUP_CYC);

    ss_state_e         state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_tc;

    logic [CODE_W-1:0] ref_code_q, ref_code_d;
    logic              drv_en_q, drv_en_d;
    logic              ss_active_q, ss_active_d;
    logic              ss_done_q, ss_done_d;
    logic              fault_flag_q, fault_flag_d;

    // Supply and substrate pins carry no logic.
    logic unused_pins;
    assign unused_pins = ^{CELV, CELG, SUB};

    ss_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .tc_o      (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;

        if (!(en && uvlo_ok)) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF:       state_d = ST_PRECHARGE;
                ST_PRECHARGE: if (tmr_tc) state_d = ST_RAMP;
                ST_RAMP: begin
                    if (oc_fault) begin
                        state_d = ST_HICCUP;
                    end else if (tmr_tc) begin
                        if (code_q == CODE_W'(FINAL_CODE - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            code_d = code_q + CODE_W'(1);
                        end
                    end
                end
                ST_DONE:      if (oc_fault) state_d = ST_HICCUP;
                ST_HICCUP:    if (tmr_tc) state_d = ST_PRECHARGE;
                default:      state_d = ST_OFF;
            endcase
        end

        // Any state entry restarts the code; DONE is the only state that holds a nonzero code.
        if (state_d != state_q) begin
            code_d = (state_d == ST_DONE) ? CODE_W'(FINAL_CODE) : '0;
        end

        tmr_load = (state_d != state_q) || ((state_q == ST_RAMP) && tmr_tc);
        unique case (state_d)
            ST_PRECHARGE: tmr_val = CNT_W'(PRE_CYC - 1);
            ST_RAMP:      tmr_val = CNT_W'(PRESCALE - 1);
            ST_HICCUP:    tmr_val = CNT_W'(HICCUP_CYC - 1);
            default:      tmr_val = '0;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        ref_code_d   = '0;
        drv_en_d     = 1'b0;
        ss_active_d  = 1'b0;
        ss_done_d    = 1'b0;
        fault_flag_d = 1'b0;
        unique case (state_d)
            ST_PRECHARGE: ss_active_d = 1'b1;
            ST_RAMP: begin
                ss_active_d = 1'b1;
                drv_en_d    = 1'b1;
                ref_code_d  = code_d;
            end
            ST_DONE: begin
                ss_done_d  = 1'b1;
                drv_en_d   = 1'b1;
                ref_code_d = code_d;
            end
            ST_HICCUP:    fault_flag_d = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            code_q       <= '0;
            ref_code_q   <= '0;
            drv_en_q     <= 1'b0;
            ss_active_q  <= 1'b0;
            ss_done_q    <= 1'b0;
            fault_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            ref_code_q   <= ref_code_d;
            drv_en_q     <= drv_en_d;
            ss_active_q  <= ss_active_d;
            ss_done_q    <= ss_done_d;
            fault_flag_q <= fault_flag_d;
        end
    end

    assign ref_code   = ref_code_q;
    assign drv_en     = drv_en_q;
    assign ss_active  = ss_active_q;
    assign ss_done    = ss_done_q;
    assign fault_flag = fault_flag_q;

endmodule

// File: doc/stepdown_softstart_ctrl.md
STEPDOWN_SOFTSTART_CTRL -- requirements
Module: stepdown_softstart_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 6: width of the soft-start reference code.
REQ-002 SHALL have parameter FINAL_CODE, default 63: ramp end code, valid range 1..2^CODE_W-1.
REQ-003 SHALL have parameter PRESCALE, default 16: clocks per code step, valid range 1..256.
REQ-004 SHALL have parameter PRE_CYC, default 32: precharge wait in clocks, valid range 1..1024.
REQ-005 SHALL have parameter HICCUP_CYC, default 1024: fault off-time in clocks, valid range 1..65535.
REQ-006 SHALL have the ports below, one per line as name, direction, width, meaning:
 - clk  in  1  single clock; all state changes on its rising edge.
 - rst  in  1  asynchronous, active-high reset.
 - CELV  in  1  supply pin; no logic function.
 - CELG  in  1  ground pin; no logic function.
 - SUB  in  1  substrate pin; no logic function.
 - en  in  1  converter enable request; synchronous level.
 - uvlo_ok  in  1  input supply above UVLO threshold.
 - oc_fault  in  1  overcurrent comparator output; one clock high is a fault.
 - ref_code  out  CODE_W  soft-start DAC code.
 - drv_en  out  1  power-stage enable.
 - ss_active  out  1  high in PRECHARGE or RAMP.
 - ss_done  out  1  high in DONE.
 - fault_flag  out  1  high in HICCUP.

Function
REQ-007 SHALL implement a state machine with five states: OFF, PRECHARGE, RAMP, DONE, HICCUP.
REQ-008 OFF: outputs all 0; go to PRECHARGE when en=1 and uvlo_ok=1.
REQ-009 PRECHARGE: drv_en=0, ref_code=0; count PRE_CYC clocks, then go to RAMP.
REQ-010 RAMP: drv_en=1; ref_code starts at 0 and increments by 1 every PRESCALE clocks; on the clock ref_code becomes FINAL_CODE, next state is DONE.
REQ-011 RAMP duration SHALL be exactly FINAL_CODE*PRESCALE clocks from RAMP entry to DONE entry.
REQ-012 ref_code SHALL saturate at FINAL_CODE and never wrap.
REQ-013 DONE: drv_en=1, ref_code=FINAL_CODE, ss_done=1; hold until exit.
REQ-014 oc_fault=1 in RAMP or DONE SHALL enter HICCUP next clock; in HICCUP drv_en=0, ref_code=0, fault_flag=1.
REQ-015 HICCUP: count HICCUP_CYC clocks, then go to PRECHARGE if en=1 and uvlo_ok=1, else go to OFF.
REQ-016 oc_fault SHALL be ignored in OFF, PRECHARGE and HICCUP; it does not restart the hiccup timer.
REQ-017 en=0 or uvlo_ok=0 in any state SHALL go to OFF next clock and override a simultaneous oc_fault.
REQ-018 Every state entry SHALL clear the cycle and prescale counters.
REQ-019 All outputs SHALL be registered, giving one clock of latency from state change to output change.

Reset
REQ-020 rst=1 SHALL asynchronously force OFF, clear all counters, and drive all outputs to 0.
REQ-021 Reset release SHALL be synchronous to clk; first transition possible on the first edge after release.
REQ-022 Reset asserted mid-RAMP or mid-HICCUP SHALL discard progress; the next start begins at PRECHARGE.

Structure
REQ-023 The state enum and default parameter constants SHALL live in shared package stepdown_pkg.
REQ-024 A single sub-module ss_timer SHALL provide the loadable down-counter with terminal-count pulse, reused for PRE_CYC, PRESCALE and HICCUP_CYC.
REQ-025 The counter width SHALL be sized for the largest of PRE_CYC, PRESCALE and HICCUP_CYC.

Verification (PRESCALE=4, PRE_CYC=8, HICCUP_CYC=32, FINAL_CODE=63)
REQ-026 Normal start: en=1, uvlo_ok=1 from reset -> drv_en rises after 8 clocks in PRECHARGE; ref_code steps every 4 clocks; ss_done=1 exactly 252 clocks after RAMP entry.
REQ-027 Fault in RAMP: one-clock oc_fault at ref_code=20 -> next clock drv_en=0, ref_code=0, fault_flag=1 for 32 clocks; then PRECHARGE, then a full ramp from 0.
REQ-028 Simultaneous events: en=0 and oc_fault=1 on the same clock in DONE -> OFF, fault_flag stays 0.
REQ-029 UVLO during HICCUP: uvlo_ok=0 at hiccup count 10 -> OFF next clock; uvlo_ok=1 -> restart from PRECHARGE.
REQ-030 Async reset mid-RAMP at ref_code=40: rst pulse between edges -> outputs 0 immediately; after release with en=1 -> PRECHARGE 8 clocks, ramp from 0.
REQ-031 Saturation: hold DONE 1000 clocks -> ref_code stays 63, no wrap.
